// File: rtl/einsum_mult_pipe_pkg.sv
// Shared types and sentinel helpers for the log-domain einsum multiplier.
package einsum_pkg;

  typedef enum logic [1:0] {
    MODE_LSE  = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_RSV2 = 2'b10,
    MODE_RSV3 = 2'b11
  } pe_mode_e;

  // Most negative two's complement value of the given width (log of zero).
  function automatic logic [63:0] lse_neg_inf(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic logic [63:0] lse_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/einsum_mult_lane.sv
// Combinational single-lane log-domain multiply (saturating add with NEG_INF sentinel).
module einsum_mult_lane
  import einsum_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 24
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [1:0]            mode,
  input  logic                  bypass,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  sat
);

  localparam logic [DATA_WIDTH-1:0] NEG_INF    = DATA_WIDTH'(lse_neg_inf(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] MAXV       = DATA_WIDTH'(lse_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] NEG_INF_P1 = NEG_INF + DATA_WIDTH'(1);
  localparam logic signed [DATA_WIDTH:0] SUM_HI = {1'b0, MAXV};
  localparam logic signed [DATA_WIDTH:0] SUM_LO = {1'b1, NEG_INF_P1};

  logic [DATA_WIDTH-1:0]        a_d;
  logic [DATA_WIDTH-1:0]        b_d;
  logic [DATA_WIDTH-1:0]        r;
  logic                         r_sat;
  logic signed [DATA_WIDTH:0]   sum;

  assign a_d = a[DATA_WIDTH-1:0];
  assign b_d = b[DATA_WIDTH-1:0];
  assign sum = $signed({a_d[DATA_WIDTH-1], a_d}) + $signed({b_d[DATA_WIDTH-1], b_d});

  generate
    if (WORD_WIDTH > DATA_WIDTH) begin : g_hi
      logic unused_b_hi;
      assign unused_b_hi = ^b[WORD_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    r     = NEG_INF;
    r_sat = 1'b0;
    case (pe_mode_e'(mode))
      MODE_LSE: begin
        // NEG_INF is absorbing; the clamp floor is NEG_INF+1 so a finite sum never becomes the sentinel.
        if (a_d == NEG_INF || b_d == NEG_INF) begin
          r = NEG_INF;
        end else if (sum > SUM_HI) begin
          r     = MAXV;
          r_sat = 1'b1;
        end else if (sum < SUM_LO) begin
          r     = NEG_INF_P1;
          r_sat = 1'b1;
        end else begin
          r = sum[DATA_WIDTH-1:0];
        end
      end
      MODE_WRAP: r = sum[DATA_WIDTH-1:0];
      default:   r = NEG_INF;
    endcase

    if (bypass) begin
      result = a;
      sat    = 1'b0;
    end else begin
      result = WORD_WIDTH'(r);
      sat    = r_sat;
    end
  end

endmodule

// File: rtl/einsum_mult_pipe.sv
// Multi-lane elastic log-domain multiplier: arithmetic in stage 0, PIPE_DEPTH-cycle valid/ready pipe.
// Optional saturation statistics counter enabled by EINSUM_MULT_PIPE_STATS_EN.
module einsum_mult_pipe
  import einsum_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 24,
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        bypass,
  input  logic [1:0]                  pe_mode,
  input  logic [LANES*WORD_WIDTH-1:0] operand_a,
  input  logic [LANES*WORD_WIDTH-1:0] operand_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*WORD_WIDTH-1:0] product_out,
  output logic [LANES-1:0]            out_sat
`ifdef EINSUM_MULT_PIPE_STATS_EN
  ,
  input  logic                        clear_stats,
  output logic [31:0]                 sat_count
`endif
);

  localparam int BW = LANES * WORD_WIDTH;

  logic [BW-1:0]         lane_res;
  logic [LANES-1:0]      lane_sat;
  logic [PIPE_DEPTH-1:0] vld;
  logic [PIPE_DEPTH-1:0] stage_rdy;
  logic                  rdy_next;
  logic [BW-1:0]         dat [PIPE_DEPTH];
  logic [LANES-1:0]      sat [PIPE_DEPTH];

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      einsum_mult_lane #(
        .WORD_WIDTH(WORD_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .a      (operand_a[i*WORD_WIDTH +: WORD_WIDTH]),
        .b      (operand_b[i*WORD_WIDTH +: WORD_WIDTH]),
        .mode   (pe_mode),
        .bypass (bypass),
        .result (lane_res[i*WORD_WIDTH +: WORD_WIDTH]),
        .sat    (lane_sat[i])
      );
    end
  endgenerate

  // Ready ripples back from the output; a stage may load when empty or when its successor drains.
  always_comb begin
    rdy_next  = out_ready;
    stage_rdy = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      stage_rdy[k] = enable & (~vld[k] | rdy_next);
      rdy_next     = stage_rdy[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        dat[k] <= '0;
        sat[k] <= '0;
      end
    end else begin
      if (stage_rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0] <= lane_res;
          sat[0] <= lane_sat;
        end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (stage_rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            dat[k] <= dat[k-1];
            sat[k] <= sat[k-1];
          end
        end
      end
    end
  end

  assign in_ready    = stage_rdy[0] & ~rst;
  assign out_valid   = vld[PIPE_DEPTH-1];
  assign product_out = dat[PIPE_DEPTH-1];
  assign out_sat     = sat[PIPE_DEPTH-1];

`ifdef EINSUM_MULT_PIPE_STATS_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready & enable;

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      sat_count <= '0;
    end else if (out_fire && (|out_sat) && (sat_count != 32'hFFFF_FFFF)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule

// File: tb/tb_einsum_mult_pipe.sv
// Self-checking bench: directed vector table, stall/reset/freeze sequences, randomized traffic vs model.
module tb_einsum_mult_pipe;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int BW = W * L;

  logic          clk = 1'b0;
  logic          rst, enable, in_valid, in_ready, bypass, out_valid, out_ready;
  logic [1:0]    pe_mode;
  logic [BW-1:0] operand_a, operand_b, product_out;
  logic [L-1:0]  out_sat;
`ifdef EINSUM_MULT_PIPE_STATS_EN
  logic          clear_stats;
  logic [31:0]   sat_count;
`endif

  always #5 clk = ~clk;

  einsum_mult_pipe dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .bypass(bypass), .pe_mode(pe_mode), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .product_out(product_out), .out_sat(out_sat)
`ifdef EINSUM_MULT_PIPE_STATS_EN
    , .clear_stats(clear_stats), .sat_count(sat_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];
  logic [L-1:0]  sat_q[$];
  logic [BW-1:0] cur_exp;
  logic [L-1:0]  cur_sat;
  logic          in_fire_last;
  int            model_sat_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on signed 24-bit log values.
  function automatic void ref_lane(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                   input logic byp, output logic [31:0] r, output logic s);
    longint sa, sb, sum, v;
    longint lo = -(longint'(1) << 23);
    longint hi = (longint'(1) << 23) - 1;
    sa = a[23] ? longint'(a[23:0]) - (longint'(1) << 24) : longint'(a[23:0]);
    sb = b[23] ? longint'(b[23:0]) - (longint'(1) << 24) : longint'(b[23:0]);
    sum = sa + sb;
    s = 1'b0;
    v = lo;
    if (m == 2'd0) begin
      if (sa == lo || sb == lo) v = lo;
      else if (sum > hi) begin v = hi; s = 1'b1; end
      else if (sum < lo + 1) begin v = lo + 1; s = 1'b1; end
      else v = sum;
    end else if (m == 2'd1) begin
      v = sum;
    end
    r = {8'h00, v[23:0]};
    if (byp) begin
      r = a;
      s = 1'b0;
    end
  endfunction

  function automatic void ref_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [1:0] m,
                                   input logic byp, output logic [BW-1:0] p, output logic [L-1:0] s);
    logic [31:0] rw;
    logic        rs;
    for (int i = 0; i < L; i++) begin
      ref_lane(a[i*W +: W], b[i*W +: W], m, byp, rw, rs);
      p[i*W +: W] = rw;
      s[i]        = rs;
    end
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 6)
      0: w[23:0] = 24'h800000;
      1: w[23:0] = 24'h7FFFFF;
      2: w[23:0] = 24'h800001;
      3: w[23:0] = 24'h7FFF00 | 24'($urandom % 256);
      default: ;
    endcase
    return w;
  endfunction

  task automatic rnd_beat(output logic [BW-1:0] a, output logic [BW-1:0] b,
                          output logic [1:0] m, output logic byp);
    int r;
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = rnd_word();
      b[i*W +: W] = rnd_word();
    end
    r   = int'($urandom % 8);
    m   = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : 2'(r - 4);
    byp = ($urandom % 8) == 0;
  endtask

  // One clock: settle, record handshakes against the scoreboard, advance to next sample point.
  task automatic tick();
    logic [BW-1:0] e;
    logic [L-1:0]  s;
    #1;
    in_fire_last = in_valid && in_ready;
    if (out_valid && out_ready && enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        s = sat_q.pop_front();
        check("beat_data", product_out, e);
        check("beat_sat", out_sat, s);
        if (s != 0) model_sat_cnt++;
      end
    end
    if (in_fire_last) begin
      exp_q.push_back(cur_exp);
      sat_q.push_back(cur_sat);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  m;
    logic        byp;
    logic [31:0] e;
    logic        es;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BW-1:0] ba[6], bb[6], be[6];
    logic [L-1:0]  bs[6];
    logic [1:0]    bm[6];
    logic [BW-1:0] hold, ra, rb;
    logic [1:0]    rm;
    logic          rbyp, have, holding;
    int            lat, sent, guard;

    tbl[0] = '{32'h0000_0010, 32'h0000_0020, 2'd0, 1'b0, 32'h0000_0030, 1'b0};
    tbl[1] = '{32'h007F_FFF0, 32'h0000_0100, 2'd0, 1'b0, 32'h007F_FFFF, 1'b1};
    tbl[2] = '{32'h0080_0001, 32'h00FF_FFFF, 2'd0, 1'b0, 32'h0080_0001, 1'b1};
    tbl[3] = '{32'h0080_0000, 32'h0012_3456, 2'd0, 1'b0, 32'h0080_0000, 1'b0};
    tbl[4] = '{32'h007F_FFFF, 32'h0000_0001, 2'd1, 1'b0, 32'h0080_0000, 1'b0};
    tbl[5] = '{32'hDEAD_BEEF, 32'h1234_5678, 2'd3, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[6] = '{32'hAB00_0010, 32'hCD00_0020, 2'd0, 1'b0, 32'h0000_0030, 1'b0};

    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    bypass = 1'b0; pe_mode = 2'd0; operand_a = '0; operand_b = '0;
`ifdef EINSUM_MULT_PIPE_STATS_EN
    clear_stats = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product_out, 0);
    check("rst_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef EINSUM_MULT_PIPE_STATS_EN
    check("rst_sat_count", sat_count, 0);
`endif
    rst = 1'b0;

    // Directed vectors, all lanes carrying the same operands.
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      operand_a = {L{tbl[i].a}};
      operand_b = {L{tbl[i].b}};
      pe_mode   = tbl[i].m;
      bypass    = tbl[i].byp;
      cur_exp   = {L{tbl[i].e}};
      cur_sat   = {L{tbl[i].es}};
      tick();
      check("tbl_accept", in_fire_last, 1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      if (i == 0) check("latency", lat, 2);
      tick();
      check("tbl_drained", exp_q.size(), 0);
      exp_q.delete();
      sat_q.delete();
    end
    bypass = 1'b0;

    // Six beats against a 5-cycle output stall.
    for (int i = 0; i < 6; i++) begin
      rnd_beat(ba[i], bb[i], bm[i], rbyp);
      ref_beat(ba[i], bb[i], bm[i], 1'b0, be[i], bs[i]);
    end
    out_ready = 1'b0;
    sent = 0;
    have = 1'b0;
    hold = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      operand_a = ba[sent]; operand_b = bb[sent]; pe_mode = bm[sent];
      cur_exp = be[sent]; cur_sat = bs[sent];
      tick();
      if (in_fire_last) sent++;
      if (out_valid) begin
        if (!have) begin
          hold = product_out;
          have = 1'b1;
        end else begin
          check("stall_hold", product_out, hold);
        end
      end
    end
    check("stall_accepts", sent, 2);
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    guard = 0;
    while (sent < 6 && guard < 50) begin
      in_valid = 1'b1;
      operand_a = ba[sent]; operand_b = bb[sent]; pe_mode = bm[sent];
      cur_exp = be[sent]; cur_sat = bs[sent];
      tick();
      if (in_fire_last) sent++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("stall_all_out", exp_q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      operand_a = ba[i]; operand_b = bb[i]; pe_mode = bm[i];
      cur_exp = be[i]; cur_sat = bs[i];
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product_out, 0);
    rst = 1'b0;
    exp_q.delete();
    sat_q.delete();
    model_sat_cnt = 0;
`ifdef EINSUM_MULT_PIPE_STATS_EN
    check("midrst_sat_count", sat_count, 0);
`endif
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_dropped", out_valid, 0);

    // enable=0 freezes a waiting result and blocks input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    operand_a = ba[2]; operand_b = bb[2]; pe_mode = bm[2];
    cur_exp = be[2]; cur_sat = bs[2];
    tick();
    in_valid = 1'b0;
    tick();
    hold = product_out;
    check("freeze_pre_valid", out_valid, 1);
    enable = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    operand_a = ba[3]; operand_b = bb[3]; pe_mode = bm[3];
    cur_exp = be[3]; cur_sat = bs[3];
    for (int c = 0; c < 3; c++) begin
      tick();
      check("freeze_in_ready", in_ready, 0);
      check("freeze_valid", out_valid, 1);
      check("freeze_hold", product_out, hold);
    end
    in_valid = 1'b0;
    enable = 1'b1;
    tick();
    check("freeze_release", exp_q.size(), 0);

    // Randomized traffic with stalls and enable drops.
    holding = 1'b0;
    ra = '0; rb = '0; rm = '0; rbyp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!holding) begin
        rnd_beat(ra, rb, rm, rbyp);
        in_valid = ($urandom % 4) != 0;
      end
      operand_a = ra; operand_b = rb; pe_mode = rm; bypass = rbyp;
      ref_beat(ra, rb, rm, rbyp, cur_exp, cur_sat);
      out_ready = ($urandom % 3) != 0;
      enable    = ($urandom % 10) != 0;
      tick();
      holding = in_valid && !in_fire_last;
    end
    in_valid = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("rand_drain", exp_q.size(), 0);
    check("rand_idle", out_valid, 0);

`ifdef EINSUM_MULT_PIPE_STATS_EN
    check("sat_count", sat_count, model_sat_cnt);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("sat_count_clear", sat_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
